// File: rtl/sram_mult_pkg.sv
// Shared sizing constants and payload types for the SRAM compute-in-memory multiplier.
package sram_mult_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned ADDR_COUNT = 32;
    localparam int unsigned ADDR_WIDTH = $clog2(ADDR_COUNT);
    localparam int unsigned MULT_WIDTH = 2 * DATA_WIDTH;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [MULT_WIDTH-1:0] prod_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/sram_mult_core_sram_weight_array.sv
// Single-port weight storage: synchronous write, asynchronous read.
module sram_weight_array
    import sram_mult_pkg::*;
(
    input  logic  clk,
    input  logic  we,
    input  addr_t addr,
    input  data_t wr_data,
    output data_t rd_data_c
);

    data_t mem [ADDR_COUNT];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[addr];

endmodule

// File: rtl/sram_mult_core.sv
// Compute-in-memory multiplier: loads ADDR_COUNT weights, then multiplies each operand
// by the weight at a wrapping read pointer. Define SIGNED_MULT_EN for two's-complement math.
module sram_mult_core
    import sram_mult_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pe_ce,
    input  logic                  init_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [MULT_WIDTH-1:0] data_out,
    output logic                  init_done,
    output logic                  valid_out
);

    localparam addr_t LAST_ADDR = addr_t'(ADDR_COUNT - 1);

    addr_t wr_ptr;
    addr_t rd_ptr;
    logic  load_lock;
    logic  init_en_q;

    logic  reload_c;
    logic  load_c;
    logic  compute_c;
    logic  we_c;
    addr_t wr_addr_c;
    addr_t mem_addr_c;
    data_t weight_c;
    prod_t prod_c;

    // Reload restarts a finished load at address 0 on a fresh init_enable rising edge.
    always_comb begin
        reload_c   = init_enable && !init_en_q && init_done;
        load_c     = pe_ce && init_enable && (!load_lock || reload_c);
        compute_c  = pe_ce && !init_enable && init_done;
        we_c       = rst_n && load_c;
        wr_addr_c  = reload_c ? '0 : wr_ptr;
        mem_addr_c = load_c ? wr_addr_c : rd_ptr;
    end

    sram_weight_array u_weights (
        .clk       (clk),
        .we        (we_c),
        .addr      (mem_addr_c),
        .wr_data   (data_in),
        .rd_data_c (weight_c)
    );

`ifdef SIGNED_MULT_EN
    logic signed [MULT_WIDTH-1:0] op_a_s;
    logic signed [MULT_WIDTH-1:0] op_b_s;

    always_comb begin
        op_a_s = {{DATA_WIDTH{data_in[DATA_WIDTH-1]}}, data_in};
        op_b_s = {{DATA_WIDTH{weight_c[DATA_WIDTH-1]}}, weight_c};
        prod_c = prod_t'(op_a_s * op_b_s);
    end
`else
    always_comb begin
        prod_c = prod_t'(data_in) * prod_t'(weight_c);
    end
`endif

    // Pointer, lock and output registers; pe_ce low holds everything but valid_out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            load_lock <= 1'b0;
            init_en_q <= 1'b0;
            init_done <= 1'b0;
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (pe_ce) begin
            valid_out <= 1'b0;
            init_en_q <= init_enable;
            if (load_c) begin
                if (reload_c) begin
                    init_done <= 1'b0;
                    rd_ptr    <= '0;
                end
                if (wr_addr_c == LAST_ADDR) begin
                    wr_ptr    <= '0;
                    init_done <= 1'b1;
                    load_lock <= 1'b1;
                end else begin
                    wr_ptr    <= wr_addr_c + 1'b1;
                    load_lock <= 1'b0;
                end
            end else if (compute_c) begin
                data_out  <= prod_c;
                valid_out <= 1'b1;
                rd_ptr    <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
            end
        end else begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_mult_core.sv
// Randomized self-checking bench for sram_mult_core against a behavioural weight/pointer model.
module tb_sram_mult_core;
    import sram_mult_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  pe_ce;
    logic  init_enable;
    data_t data_in;
    prod_t data_out;
    logic  init_done;
    logic  valid_out;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    data_t m_mem [ADDR_COUNT];
    int    m_wcount;
    int    m_rd;
    logic  m_done;
    logic  m_prev;
    prod_t exp_out;
    logic  exp_valid;

    sram_mult_core dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pe_ce       (pe_ce),
        .init_enable (init_enable),
        .data_in     (data_in),
        .data_out    (data_out),
        .init_done   (init_done),
        .valid_out   (valid_out)
    );

    always #5 clk = ~clk;

    function automatic prod_t ref_prod(input data_t a, input data_t w);
        longint pa;
        longint pw;
`ifdef SIGNED_MULT_EN
        pa = longint'($signed(a));
        pw = longint'($signed(w));
`else
        pa = longint'(a);
        pw = longint'(w);
`endif
        return prod_t'(pa * pw);
    endfunction

    function automatic data_t rnd();
        return data_t'($urandom);
    endfunction

    // Apply one cycle of inputs, advance the model, and settle just after the edge.
    task automatic drive(input logic r, input logic p, input logic e, input data_t d);
        rst_n = r;
        pe_ce = p;
        init_enable = e;
        data_in = d;
        if (!r) begin
            m_wcount = 0;
            m_rd = 0;
            m_done = 1'b0;
            m_prev = 1'b0;
            exp_out = '0;
            exp_valid = 1'b0;
        end else if (!p) begin
            exp_valid = 1'b0;
        end else begin
            exp_valid = 1'b0;
            if (e) begin
                if (m_done && !m_prev) begin
                    m_done = 1'b0;
                    m_rd = 0;
                    m_wcount = 0;
                end
                if (m_wcount < ADDR_COUNT) begin
                    m_mem[m_wcount] = d;
                    m_wcount++;
                    if (m_wcount == ADDR_COUNT) m_done = 1'b1;
                end
            end else if (m_done) begin
                exp_out = ref_prod(d, m_mem[m_rd]);
                exp_valid = 1'b1;
                m_rd = (m_rd + 1) % ADDR_COUNT;
            end
            m_prev = e;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 1'b1, rnd());
        drive(1'b0, 1'b1, 1'b0, rnd());
        checks++;
        if (data_out !== '0) begin
            failures++; $display("FAIL reset_data_out: got %h want 0", data_out);
        end
        checks++;
        if (valid_out !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b want 0", valid_out);
        end
        checks++;
        if (init_done !== 1'b0) begin
            failures++; $display("FAIL reset_init_done: got %b want 0", init_done);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, rnd());
            checks++;
            if (valid_out !== 1'b0 || data_out !== '0) begin
                failures++;
                $display("FAIL compute_before_load: valid=%b data=%h want 0/0", valid_out, data_out);
            end
        end
    endtask

    task automatic test_load_and_stream();
        for (int i = 0; i < ADDR_COUNT; i++) begin
            drive(1'b1, 1'b1, 1'b1, data_t'(i + 1));
            checks++;
            if (init_done !== (i == ADDR_COUNT - 1)) begin
                failures++;
                $display("FAIL load_init_done[%0d]: got %b want %b", i, init_done, i == ADDR_COUNT - 1);
            end
        end
        for (int k = 0; k <= ADDR_COUNT; k++) begin
            drive(1'b1, 1'b1, 1'b0, data_t'(3));
            checks++;
            if (valid_out !== 1'b1 || data_out !== prod_t'(3 * ((k % ADDR_COUNT) + 1))) begin
                failures++;
                $display("FAIL stream3[%0d]: valid=%b data=%h want 1/%h", k, valid_out, data_out,
                         prod_t'(3 * ((k % ADDR_COUNT) + 1)));
            end
        end
    endtask

    task automatic test_extremes();
        prod_t want;
`ifdef SIGNED_MULT_EN
        want = 32'h0000_0001;
`else
        want = 32'hFFFE_0001;
`endif
        drive(1'b1, 1'b1, 1'b1, 16'hFFFF);
        checks++;
        if (init_done !== 1'b0) begin
            failures++; $display("FAIL reload_drops_done: got %b want 0", init_done);
        end
        for (int i = 1; i < ADDR_COUNT; i++) drive(1'b1, 1'b1, 1'b1, rnd());
        drive(1'b1, 1'b1, 1'b0, 16'hFFFF);
        checks++;
        if (valid_out !== 1'b1 || data_out !== want) begin
            failures++; $display("FAIL extreme_ffff: valid=%b data=%h want 1/%h", valid_out, data_out, want);
        end
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b1, 1'b0, rnd());
            checks++;
            if (valid_out !== exp_valid || data_out !== exp_out) begin
                failures++;
                $display("FAIL random_compute[%0d]: valid=%b data=%h want %b/%h", i, valid_out, data_out,
                         exp_valid, exp_out);
            end
        end
    endtask

    task automatic test_pe_ce_freeze();
        prod_t held;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, rnd());
        held = exp_out;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, i[0], rnd());
            checks++;
            if (valid_out !== 1'b0 || data_out !== held || init_done !== 1'b1) begin
                failures++;
                $display("FAIL freeze[%0d]: valid=%b data=%h done=%b want 0/%h/1", i, valid_out, data_out,
                         init_done, held);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, rnd());
            checks++;
            if (valid_out !== exp_valid || data_out !== exp_out) begin
                failures++;
                $display("FAIL resume[%0d]: valid=%b data=%h want %b/%h", i, valid_out, data_out,
                         exp_valid, exp_out);
            end
        end
    endtask

    task automatic test_overflow();
        data_t first [ADDR_COUNT];
        data_t d;
        for (int i = 0; i < 40; i++) begin
            d = rnd();
            if (i < ADDR_COUNT) first[i] = d;
            drive(1'b1, 1'b1, 1'b1, d);
        end
        checks++;
        if (init_done !== 1'b1) begin
            failures++; $display("FAIL overflow_done: got %b want 1", init_done);
        end
        for (int k = 0; k < ADDR_COUNT; k++) begin
            d = rnd();
            drive(1'b1, 1'b1, 1'b0, d);
            checks++;
            if (valid_out !== 1'b1 || data_out !== ref_prod(d, first[k])) begin
                failures++;
                $display("FAIL overflow_keep[%0d]: valid=%b data=%h want 1/%h", k, valid_out, data_out,
                         ref_prod(d, first[k]));
            end
        end
    endtask

    task automatic test_partial_load();
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 1'b1, rnd());
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, rnd());
            checks++;
            if (valid_out !== 1'b0 || init_done !== 1'b0) begin
                failures++;
                $display("FAIL partial_blocked[%0d]: valid=%b done=%b want 0/0", i, valid_out, init_done);
            end
        end
        for (int i = 10; i < ADDR_COUNT; i++) begin
            drive(1'b1, 1'b1, 1'b1, rnd());
            checks++;
            if (init_done !== m_done) begin
                failures++; $display("FAIL partial_resume_done[%0d]: got %b want %b", i, init_done, m_done);
            end
        end
        for (int k = 0; k < ADDR_COUNT; k++) begin
            drive(1'b1, 1'b1, 1'b0, rnd());
            checks++;
            if (valid_out !== exp_valid || data_out !== exp_out) begin
                failures++;
                $display("FAIL partial_compute[%0d]: valid=%b data=%h want %b/%h", k, valid_out, data_out,
                         exp_valid, exp_out);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, rnd());
        drive(1'b0, 1'b1, 1'b0, rnd());
        checks++;
        if (data_out !== '0 || valid_out !== 1'b0 || init_done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: data=%h valid=%b done=%b want 0/0/0", data_out, valid_out, init_done);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, rnd());
            checks++;
            if (valid_out !== 1'b0) begin
                failures++; $display("FAIL post_reset_blocked[%0d]: valid=%b want 0", i, valid_out);
            end
        end
        for (int i = 0; i < ADDR_COUNT; i++) drive(1'b1, 1'b1, 1'b1, rnd());
        checks++;
        if (init_done !== 1'b1) begin
            failures++; $display("FAIL reload_after_reset_done: got %b want 1", init_done);
        end
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'b1, 1'b0, rnd());
            checks++;
            if (valid_out !== exp_valid || data_out !== exp_out) begin
                failures++;
                $display("FAIL post_reset_compute[%0d]: valid=%b data=%h want %b/%h", k, valid_out, data_out,
                         exp_valid, exp_out);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        pe_ce = 1'b0;
        init_enable = 1'b0;
        data_in = '0;
        m_wcount = 0;
        m_rd = 0;
        m_done = 1'b0;
        m_prev = 1'b0;
        exp_out = '0;
        exp_valid = 1'b0;
        for (int i = 0; i < ADDR_COUNT; i++) m_mem[i] = '0;
        test_reset();
        test_load_and_stream();
        test_extremes();
        test_pe_ce_freeze();
        test_overflow();
        test_partial_load();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
